// File: rtl/read_burst_ctrl.sv
// read_burst_ctrl: issues one read request per row of a burst, waits for the
// read stage's acknowledge before the next request, and accumulates returned
// words. A per-request wait counter aborts the burst if an ack never arrives.
module read_burst_ctrl #(
  parameter int ROW_W   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ROW_W-1:0]        start_row,
  input  logic [ROW_W:0]          count,
  output logic                    rd_valid,
  output logic [ROW_W-1:0]        rd_row,
  input  logic                    rd_ack,
  input  logic [DATA_W-1:0]       rd_data,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W+ROW_W-1:0] sum,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0]       TO_L    = 8'(TIMEOUT);
  localparam logic [ROW_W-1:0] ROW_ONE = 1;
  localparam logic [ROW_W:0]   REM_ONE = 1;

  state_t         state;
  logic [ROW_W:0] remaining;
  logic [7:0]     wcnt;

  // Burst sequencer; every output is a register updated on state transitions.
  // rd_row doubles as the current-row register: it advances on each ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      wcnt        <= '0;
      rd_valid    <= 1'b0;
      rd_row      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          rd_valid <= 1'b0;
          if (start) begin
            sum         <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            if (count != '0) begin
              remaining <= count;
              rd_row    <= start_row;
              rd_valid  <= 1'b1;
              state     <= ISSUE;
            end else begin
              // empty burst: complete without touching the read stage
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          rd_valid <= 1'b0;
          wcnt     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // an ack on the final wait cycle takes priority over the timeout
          if (rd_ack) begin
            sum       <= sum + {{ROW_W{1'b0}}, rd_data};
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_row   <= rd_row + ROW_ONE;
              rd_valid <= 1'b1;
              state    <= ISSUE;
            end
          end else if (wcnt + 8'd1 == TO_L) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_burst_ctrl.sv
// Bench for read_burst_ctrl: directed vector table, randomized bursts checked
// against a request-level model, and hand sequences for stray acks and reset.
module tb_read_burst_ctrl;

  localparam int ROW_W = 4, DATA_W = 32, TO = 15;

  logic              clk = 1'b0, rst = 1'b1;
  logic              start = 1'b0;
  logic [ROW_W-1:0]  start_row = '0;
  logic [ROW_W:0]    count = '0;
  logic              rd_valid, rd_ack = 1'b0;
  logic [ROW_W-1:0]  rd_row;
  logic [DATA_W-1:0] rd_data = '0;
  logic              busy, done, timeout_err;
  logic [DATA_W+ROW_W-1:0] sum;

  read_burst_ctrl #(.ROW_W(ROW_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .start_row(start_row), .count(count),
    .rd_valid(rd_valid), .rd_row(rd_row), .rd_ack(rd_ack), .rd_data(rd_data),
    .busy(busy), .done(done), .sum(sum), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // per-request responder behaviour: ack delay after rd_valid (0 = never) and data
  int          dly_arr [16];
  logic [31:0] data_arr[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // request-level model: requests proceed until one is not acked within TO cycles
  task automatic model(input int cnt, output logic [35:0] esum, output bit eerr,
                       output int epulses);
    esum = '0; eerr = 0; epulses = 0;
    for (int i = 0; i < cnt; i++) begin
      epulses++;
      if (dly_arr[i] >= 1 && dly_arr[i] <= TO) esum += 36'(data_arr[i]);
      else begin eerr = 1; break; end
    end
  endtask

  task automatic run_burst(input int srow, input int cnt, input bit mid_start,
                           input logic [35:0] esum, input bit eerr, input int epulses);
    int cyc, nreq, ack_at, ndone, done_cyc, first_cyc;
    bit prev_v;
    logic [31:0] ack_d;
    @(negedge clk);
    start = 1'b1; start_row = ROW_W'(srow); count = (ROW_W+1)'(cnt);
    @(negedge clk);
    start = 1'b0; start_row = ROW_W'($urandom); count = (ROW_W+1)'($urandom_range(1, 16));
    cyc = 1; nreq = 0; ack_at = -1; ndone = 0; done_cyc = -1; first_cyc = -1; prev_v = 0;
    ack_d = '0;
    while (cyc < 600 && (done_cyc < 0 || cyc <= done_cyc + 4)) begin
      if (rd_valid) begin
        if (prev_v) chk("rd_valid_width", 2, 1);
        if (nreq < epulses) chk($sformatf("rd_row[%0d]", nreq), 64'(rd_row), 64'((srow + nreq) % 16));
        if (first_cyc < 0) first_cyc = cyc;
        if (nreq < 16 && dly_arr[nreq] > 0) begin
          ack_at = cyc + dly_arr[nreq];
          ack_d  = data_arr[nreq];
        end
        nreq++;
      end
      prev_v = rd_valid;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          if (cnt > 0) chk("busy_at_done", 64'(busy), 1);
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_after_done", 64'(busy), 0);
      rd_ack  = (cyc == ack_at);
      rd_data = rd_ack ? ack_d : $urandom;
      start   = mid_start && cyc == 3;
      @(negedge clk);
      cyc++;
    end
    rd_ack = 1'b0; start = 1'b0;
    chk("done_seen", 64'(done_cyc >= 0), 1);
    chk("done_count", 64'(ndone), 1);
    chk("rd_valid_pulses", 64'(nreq), 64'(epulses));
    if (cnt > 0) chk("first_issue_cycle", 64'(first_cyc), 1);
    chk("sum", 64'(sum), 64'(esum));
    chk("timeout_err", 64'(timeout_err), 64'(eerr));
  endtask

  typedef struct {
    int srow; int cnt; bit row_data; logic [31:0] dval; int dly; int nack; bit mid;
    logic [35:0] esum; bit eerr; int epulses;
  } vec_t;

  vec_t vecs[8];
  logic [35:0] msum;
  bit merr;
  int mp, w;

  initial begin
    vecs[0] = '{0,  1, 0, 32'h5,        3,  1,  0, 36'd5,           0, 1};
    vecs[1] = '{14, 4, 1, 32'h0,        2,  4,  0, 36'd34,          0, 4};
    vecs[2] = '{0,  16, 0, 32'hFFFFFFFF, 1, 16, 0, 36'hFFFFFFFF0,   0, 16};
    vecs[3] = '{5,  3, 0, 32'h1234,     2,  1,  0, 36'h1234,        1, 2};
    vecs[4] = '{9,  0, 0, 32'h0,        2,  0,  0, 36'd0,           0, 0};
    vecs[5] = '{2,  3, 0, 32'd10,       2,  3,  1, 36'd30,          0, 3};
    vecs[6] = '{7,  2, 0, 32'd7,        TO, 2,  0, 36'd14,          0, 2};
    vecs[7] = '{1,  1, 0, 32'd9,        TO+1, 1, 0, 36'd0,          1, 1};

    #13;
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_sum", 64'(sum), 0);
    chk("rst_err", 64'(timeout_err), 0);
    chk("rst_rd_row", 64'(rd_row), 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[k]) begin
      for (int i = 0; i < 16; i++) begin
        dly_arr[i]  = (i < vecs[k].nack) ? vecs[k].dly : 0;
        data_arr[i] = vecs[k].row_data ? 32'((vecs[k].srow + i) % 16 + 1) : vecs[k].dval;
      end
      run_burst(vecs[k].srow, vecs[k].cnt, vecs[k].mid, vecs[k].esum, vecs[k].eerr, vecs[k].epulses);
    end

    // stray acks while idle must not disturb the held results
    @(negedge clk); rd_ack = 1'b1; rd_data = 32'hABC;
    repeat (2) @(negedge clk);
    rd_ack = 1'b0;
    chk("idle_ack_sum", 64'(sum), 0);
    chk("idle_ack_err", 64'(timeout_err), 1);
    chk("idle_ack_valid", 64'(rd_valid), 0);

    // randomized bursts against the model
    for (int k = 0; k < 25; k++) begin
      int srow, cnt;
      srow = $urandom_range(0, 15);
      cnt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : $urandom_range(1, 5);
      for (int i = 0; i < 16; i++) begin
        dly_arr[i]  = ($urandom_range(0, 11) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(1, 5);
        data_arr[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      end
      model(cnt, msum, merr, mp);
      run_burst(srow, cnt, 1'b0, msum, merr, mp);
    end

    // async reset while waiting on the second request
    for (int i = 0; i < 16; i++) begin dly_arr[i] = 0; data_arr[i] = 32'h0; end
    @(negedge clk); start = 1'b1; start_row = 4'd3; count = 5'd4;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!rd_valid && w < 10) begin @(negedge clk); w++; end
    @(negedge clk); rd_ack = 1'b1; rd_data = 32'h55;
    @(negedge clk); rd_ack = 1'b0;
    w = 0;
    while (!rd_valid && w < 10) begin @(negedge clk); w++; end
    chk("pre_rst_sum", 64'(sum), 64'h55);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 0);
    chk("async_rst_sum", 64'(sum), 0);
    chk("async_rst_valid", 64'(rd_valid), 0);
    chk("async_rst_row", 64'(rd_row), 0);
    @(negedge clk); rst = 1'b0; rd_ack = 1'b1; rd_data = 32'h77;
    repeat (3) @(negedge clk);
    rd_ack = 1'b0;
    chk("post_rst_sum", 64'(sum), 0);
    chk("post_rst_busy", 64'(busy), 0);
    chk("post_rst_valid", 64'(rd_valid), 0);
    for (int i = 0; i < 16; i++) begin dly_arr[i] = 2; data_arr[i] = 32'(i + 100); end
    run_burst(6, 2, 1'b0, 36'd201, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/read_burst_ctrl.md
Name: read_burst_ctrl

Overview:
Upstream request sequencer for the row-read stage. It accepts a burst command (start row, row count), issues one single-cycle read request per row on the read stage's input_valid/row_num interface, and waits for each output_valid before issuing the next. It accumulates the returned 32-bit words into a running sum and reports completion or timeout to the controlling logic.

Parameters:
ROW_W, 4, row index width (16 rows)
DATA_W, 32, read data width
TIMEOUT, 15, max clk cycles to wait for rd_ack per request before abort (1..255)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-high reset
start  input  1  burst command strobe, sampled on rising clk
start_row  input  ROW_W  first row of burst
count  input  ROW_W+1  rows to read, 0..16
rd_valid  output  1  read request pulse to read stage (its input_valid)
rd_row  output  ROW_W  row index to read stage (its row_num)
rd_ack  input  1  read stage output_valid
rd_data  input  DATA_W  read stage out
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
sum  output  DATA_W+ROW_W  accumulated sum of returned words
timeout_err  output  1  set when a request timed out; sticky until next accepted start

Behaviour:
- Reset (async, immediate): state=IDLE; rd_valid=0, rd_row=0, busy=0, done=0, sum=0, timeout_err=0; internal counters cleared. Reset mid-burst abandons it; any later rd_ack is ignored.
- All outputs registered; no combinational input-to-output paths.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: start=1 with count>0 -> latch start_row into row register and count into remaining; clear sum and timeout_err; busy=1; go ISSUE. start=1 with count=0 -> clear sum and timeout_err; go DONE (no request issued). start while busy is ignored.
- ISSUE: rd_valid=1 for exactly one cycle, rd_row=current row; reload wait counter to 0; go WAIT. First rd_valid is asserted the cycle after start is sampled.
- WAIT: rd_valid=0; rd_row holds. On rd_ack=1: sum <= sum + zero-extended rd_data; remaining decrements; row increments modulo 2^ROW_W (15 wraps to 0). If remaining becomes 0, go DONE; otherwise go ISSUE (next rd_valid on the following cycle, so back-to-back requests are spaced minimum 2 cycles apart). Without rd_ack, wait counter increments; when it reaches TIMEOUT, set timeout_err=1 and go DONE (remaining requests dropped, sum retains partial value).
- rd_ack arriving on the same cycle the counter reaches TIMEOUT: the ack wins; data accumulated, no error.
- DONE: done=1 for one cycle, busy=0 on the next cycle; return IDLE. sum and timeout_err hold until the next accepted start.
- rd_ack in IDLE, ISSUE or DONE is ignored (no accumulation).
- sum width DATA_W+ROW_W; 16 x 0xFFFFFFFF = 0xFFFFFFFF0 with no overflow.

Test Plan:
- Single row: start_row=0, count=1, responder acks 3 cycles after rd_valid with rd_data=0x00000005 -> one rd_valid pulse with rd_row=0, done pulse, sum=5, timeout_err=0.
- Burst with wrap: start_row=14, count=4, data=row+1 -> rd_row sequence 14,15,0,1; sum=15+16+1+2=34; exactly 4 rd_valid pulses, each 1 cycle wide.
- Max burst overflow: count=16, every rd_data=0xFFFFFFFF -> sum=0xFFFFFFFF0, done once, busy low the cycle after done.
- Timeout: count=3, responder acks the first request only -> timeout_err=1 after TIMEOUT cycles of waiting on request 2, sum=first word, no third rd_valid, done pulses once.
- Edge cases: count=0 -> done without rd_valid, sum=0; start pulsed mid-burst -> ignored; stray rd_ack in IDLE -> sum unchanged.
- Async reset asserted in WAIT between clock edges -> all outputs 0 immediately; subsequent rd_ack ignored; a new start after reset release runs normally.
